// File: rtl/csr_unit.sv
// CSR decode and storage for the writeback stage: scratch/mscratch registers plus
// mcycle/minstret counters. Reads return the old value; updates land on the next edge.
module csr_unit #(
  parameter int NUM_SCRATCH = 4,
  parameter int COUNTER_W   = 64,
  parameter bit COUNTERS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic        CSRWrite,
  output logic        csr_illegal
);
  localparam int         HI_W       = COUNTER_W - 32;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  uimm;
  logic [11:0] addr;
  logic        unused_rd;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign uimm      = instr[19:15];
  assign addr      = instr[31:20];
  assign unused_rd = ^instr[11:7];

  logic [31:0]          mscratch_q, mscratch_d;
  logic [31:0]          scratch_q [16];
  logic [31:0]          scratch_d [16];
  logic [COUNTER_W-1:0] mcycle_q, mcycle_d;
  logic [COUNTER_W-1:0] minstret_q, minstret_d;
  logic [63:0]          mcycle_x, minstret_x;

  assign mcycle_x   = 64'(mcycle_q);
  assign minstret_x = 64'(minstret_q);

  logic        csr_op;
  logic        wr_intent;
  logic [31:0] src;
  logic        mapped;
  logic        scratch_hit;
  logic [31:0] old_val;
  logic        illegal;
  logic        commit;
  logic [31:0] new_val;

  // Set/clear forms only write when the rs1/uimm field is nonzero, whatever rs1 holds.
  always_comb begin
    csr_op    = csr_valid && (opcode == OPC_SYSTEM) && (funct3 != 3'b000);
    src       = funct3[2] ? {27'd0, uimm} : rs1_data;
    wr_intent = (funct3[1:0] == 2'b01) || (uimm != 5'd0);
  end

  always_comb begin
    mapped      = 1'b0;
    scratch_hit = 1'b0;
    old_val     = 32'd0;
    if (addr == 12'h340) begin
      mapped  = 1'b1;
      old_val = mscratch_q;
    end else if ((addr[11:4] == 8'h7C) && (32'(addr[3:0]) < NUM_SCRATCH)) begin
      mapped      = 1'b1;
      scratch_hit = 1'b1;
      old_val     = scratch_q[addr[3:0]];
    end else if (COUNTERS_EN) begin
      case (addr)
        12'hB00, 12'hC00: begin mapped = 1'b1; old_val = mcycle_x[31:0];    end
        12'hB80, 12'hC80: begin mapped = 1'b1; old_val = mcycle_x[63:32];   end
        12'hB02, 12'hC02: begin mapped = 1'b1; old_val = minstret_x[31:0];  end
        12'hB82, 12'hC82: begin mapped = 1'b1; old_val = minstret_x[63:32]; end
        default: ;
      endcase
    end
  end

  always_comb begin
    illegal = csr_op && ((funct3 == 3'b100) || !mapped ||
                         (wr_intent && (addr[11:10] == 2'b11)));
    commit  = csr_op && !illegal && wr_intent;
    case (funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign csr_rdata   = (csr_op && !illegal) ? old_val : 32'd0;
  assign CSRWrite    = commit;
  assign csr_illegal = illegal;

  // A counter write replaces that cycle's increment rather than adding to it.
  always_comb begin
    mscratch_d = mscratch_q;
    for (int i = 0; i < 16; i++) scratch_d[i] = scratch_q[i];
    mcycle_d   = mcycle_q + COUNTER_W'(1);
    minstret_d = retire ? minstret_q + COUNTER_W'(1) : minstret_q;
    if (commit) begin
      if (addr == 12'h340) mscratch_d = new_val;
      if (scratch_hit) scratch_d[addr[3:0]] = new_val;
      case (addr)
        12'hB00: mcycle_d   = {mcycle_q[COUNTER_W-1:32], new_val};
        12'hB80: mcycle_d   = {new_val[HI_W-1:0], mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[COUNTER_W-1:32], new_val};
        12'hB82: minstret_d = {new_val[HI_W-1:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mscratch_q <= '0;
      for (int i = 0; i < 16; i++) scratch_q[i] <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mscratch_q <= mscratch_d;
      for (int i = 0; i < 16; i++) scratch_q[i] <= scratch_d[i];
      mcycle_q   <= COUNTERS_EN ? mcycle_d : '0;
      minstret_q <= COUNTERS_EN ? minstret_d : '0;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected rdata/write/illegal,
// a negedge monitor pops and compares whenever a check slot is presented.
module tb_csr_unit;
  logic        clk = 1'b0;
  logic        reset, csr_valid, retire;
  logic [31:0] instr, rs1_data;
  logic [31:0] csr_rdata;
  logic        CSRWrite, csr_illegal;

  always #5 clk = ~clk;

  csr_unit #(.NUM_SCRATCH(4), .COUNTER_W(64), .COUNTERS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .instr(instr),
    .rs1_data(rs1_data), .retire(retire), .csr_rdata(csr_rdata),
    .CSRWrite(CSRWrite), .csr_illegal(csr_illegal)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        wr;
    logic        ill;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        chk_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          id_cnt = 0;
  logic [63:0] cyc;

  localparam logic [2:0] F_RW = 3'b001, F_RS = 3'b010, F_RC = 3'b011;
  localparam logic [2:0] F_BAD = 3'b100, F_RWI = 3'b101, F_RSI = 3'b110, F_RCI = 3'b111;

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [11:0] a);
    return {a, rs1, f3, 5'd1, 7'b1110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) cyc = 64'd0;
    else cyc = cyc + 64'd1;
  endtask

  task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] rs1d,
                       input logic ret, input logic [31:0] e_rdata, input logic e_wr,
                       input logic e_ill);
    exp_t e;
    instr     = ins;
    rs1_data  = rs1d;
    retire    = ret;
    csr_valid = v;
    e.rdata   = e_rdata;
    e.wr      = e_wr;
    e.ill     = e_ill;
    e.id      = id_cnt;
    id_cnt++;
    exp_q.push_back(e);
    chk_en = 1'b1;
    tick();
    chk_en    = 1'b0;
    csr_valid = 1'b0;
    retire    = 1'b0;
    instr     = 32'd0;
    rs1_data  = 32'd0;
  endtask

  task automatic cmp(input string nm, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s vec%0d got=%h expected=%h", nm, id, got, want);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard vec? output presented with no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        cmp("rdata",    mon_e.id, csr_rdata,            mon_e.rdata);
        cmp("csrwrite", mon_e.id, {31'd0, CSRWrite},    {31'd0, mon_e.wr});
        cmp("illegal",  mon_e.id, {31'd0, csr_illegal}, {31'd0, mon_e.ill});
      end
    end
  end

  initial begin
    #2_000_000;
    n_checks++;
    $display("FAIL watchdog time limit reached got=running expected=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    reset = 1'b1; csr_valid = 1'b0; retire = 1'b0; instr = 32'd0; rs1_data = 32'd0;
    cyc = 64'd0;
    tick(); tick();
    // reset state
    issue(1, enc(F_RS, 5'd0, 12'h340), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hB00), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'h7C3), 0, 0, 32'd0, 0, 0);
    reset = 1'b0;
    repeat (5) tick();
    issue(1, enc(F_RS, 5'd0, 12'hB00), 0, 0, 32'd5, 0, 0);

    // scratch read/modify/write forms
    issue(1, enc(F_RW, 5'd5, 12'h7C1), 32'hDEADBEEF, 0, 32'd0, 1, 0);
    issue(1, enc(F_RS, 5'd0, 12'h7C1), 0, 0, 32'hDEADBEEF, 0, 0);
    issue(1, enc(F_RW, 5'd2, 12'h7C0), 32'h0000_00FF, 0, 32'd0, 1, 0);
    issue(1, enc(F_RCI, 5'h0F, 12'h7C0), 0, 0, 32'h0000_00FF, 1, 0);
    issue(1, enc(F_RS, 5'd0, 12'h7C0), 0, 0, 32'h0000_00F0, 0, 0);
    issue(1, enc(F_RSI, 5'd0, 12'h7C0), 0, 0, 32'h0000_00F0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'h7C0), 32'hFFFF_FFFF, 0, 32'h0000_00F0, 0, 0);
    issue(1, enc(F_RS, 5'd3, 12'h7C0), 32'h0000_0F00, 0, 32'h0000_00F0, 1, 0);
    issue(1, enc(F_RS, 5'd0, 12'h7C0), 0, 0, 32'h0000_0FF0, 0, 0);
    issue(1, enc(F_RWI, 5'h1F, 12'h7C2), 0, 0, 32'd0, 1, 0);
    issue(1, enc(F_RS, 5'd0, 12'h7C2), 0, 0, 32'h0000_001F, 0, 0);

    // read-only shadows
    issue(1, enc(F_RS, 5'd0, 12'hC00), 0, 0, cyc[31:0], 0, 0);
    issue(1, enc(F_RS, 5'd5, 12'hC00), 32'd1, 0, 32'd0, 0, 1);
    issue(1, enc(F_RS, 5'd0, 12'hC80), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RW, 5'd0, 12'hC02), 0, 0, 32'd0, 0, 1);
    issue(1, enc(F_RC, 5'd0, 12'hB80), 32'hFFFF_FFFF, 0, 32'd0, 0, 0);

    // mcycle carry lo->hi, write wins over increment
    issue(1, enc(F_RW, 5'd6, 12'hB00), 32'hFFFF_FFFF, 0, cyc[31:0], 1, 0);
    cyc = 64'h0000_0000_FFFF_FFFF;
    issue(1, enc(F_RW, 5'd0, 12'hB80), 32'd0, 0, 32'd0, 1, 0);
    cyc = 64'h0000_0000_FFFF_FFFF;
    issue(1, enc(F_RS, 5'd0, 12'hB00), 0, 0, 32'hFFFF_FFFF, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hB80), 0, 0, 32'd1, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hC00), 0, 0, 32'd1, 0, 0);

    // minstret
    issue(1, enc(F_RS, 5'd0, 12'hB02), 0, 1, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hC02), 0, 0, 32'd1, 0, 0);
    issue(1, enc(F_RW, 5'd7, 12'hB02), 32'h0000_1234, 1, 32'd1, 1, 0);
    issue(1, enc(F_RS, 5'd0, 12'hB02), 0, 0, 32'h0000_1234, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hB82), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RW, 5'd7, 12'hB82), 32'd2, 1, 32'd0, 1, 0);
    issue(1, enc(F_RS, 5'd0, 12'hC82), 0, 0, 32'd2, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hC02), 0, 0, 32'h0000_1234, 0, 0);

    // illegal accesses and non-CSR cycles
    issue(1, enc(F_RS, 5'd0, 12'h7C4), 0, 0, 32'd0, 0, 1);
    issue(1, enc(F_RW, 5'd1, 12'h340), 32'h0000_A5A5, 0, 32'd0, 1, 0);
    issue(1, enc(F_BAD, 5'd1, 12'h340), 32'd1, 0, 32'd0, 0, 1);
    issue(1, enc(F_RS, 5'd0, 12'h340), 0, 0, 32'h0000_A5A5, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'h341), 0, 0, 32'd0, 0, 1);
    issue(1, 32'h0000_0073, 32'h1234_5678, 0, 32'd0, 0, 0);
    issue(0, enc(F_RW, 5'd1, 12'h340), 32'h1111_1111, 0, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'h340), 0, 0, 32'h0000_A5A5, 0, 0);

    // reset while counting
    reset = 1'b1;
    tick(); tick();
    issue(1, enc(F_RS, 5'd0, 12'hB00), 0, 0, 32'd0, 0, 0);
    reset = 1'b0;
    issue(1, enc(F_RS, 5'd0, 12'hB00), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'h340), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'h7C1), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hB02), 0, 0, 32'd0, 0, 0);
    issue(1, enc(F_RS, 5'd0, 12'hB00), 0, 0, 32'd4, 0, 0);

    tick();
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain leftover=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
